// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Single-port data memory target with a valid/ready request channel and a
//   valid/ready response channel. It accepts one request at a time, waits
//   LATENCY cycles, performs the word access and presents the result until
//   the initiator takes it.
//
// Parameters
//   DEPTH    number of 32-bit words of storage
//   LATENCY  wait cycles between request acceptance and response (0 allowed)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  initiator request present
//   req_ready  responder can accept a request (IDLE only)
//   req_we     1 = store, 0 = load
//   req_addr   byte address; word index is req_addr[31:2]
//   req_wdata  store data
//   req_be     store byte enables, bit i selects req_wdata[8i+7:8i]
//   rsp_valid  response present (RESP only)
//   rsp_ready  initiator accepts response
//   rsp_rdata  load data (0 for stores and errors)
//   rsp_err    misaligned or out-of-range access
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            accept;
    logic            access;

    // Captured request.
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;

    // Request actually used for the storage access.
    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic            acc_err;
    logic [IW-1:0]   acc_idx;

    logic [31:0]     mem [DEPTH];

    // With LATENCY==0 the access happens on the acceptance edge itself, so
    // the live request is used; otherwise the access happens from WAIT and
    // uses the captured copy.
    always_comb begin
        acc_we    = (state == IDLE) ? req_we    : we_q;
        acc_addr  = (state == IDLE) ? req_addr  : addr_q;
        acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
        acc_be    = (state == IDLE) ? req_be    : be_q;
        acc_err   = (acc_addr[1:0] != 2'b00) ||
                    ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
        acc_idx   = acc_addr[IW+1:2];
    end

    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        next_state = RESP;
                        access     = 1'b1;
                    end else begin
                        next_state = WAIT;
                        cnt_next   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                    access     = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
            end
        end
    end

    // The captured request is only consumed after an acceptance, so it needs
    // no reset value.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // NOTE: storage has no reset branch; clearing a RAM on reset would force
    // it into flops, and its contents must survive reset anyway. A reset edge
    // still suppresses the write so an aborted store leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && access && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
